wave_generator: RTL
===================

WAVE_GENERATOR -- requirements
Module: wave_generator

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning output/bound width in bits (N >= 2).
REQ-002 The module SHALL have parameter S, default 4, meaning step input width in bits (1 <= S <= N).
REQ-003 Port clk  input  1  clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port ena  input  1  advance enable; one step per cycle while high.
REQ-006 Port cfg_load  input  1  capture mode/lo/hi/step and restart the waveform.
REQ-007 Port mode  input  2  00 triangle, 01 saw-up, 10 saw-down, 11 one-shot ramp.
REQ-008 Port lo  input  N  lower bound, unsigned.
REQ-009 Port hi  input  N  upper bound, unsigned.
REQ-010 Port step  input  S  increment magnitude, unsigned.
REQ-011 Port out  output  N  registered waveform value.
REQ-012 Port dir  output  1  registered direction; 0 up, 1 down.
REQ-013 Port period  output  1  registered one-cycle pulse at each period boundary.
REQ-014 Port done  output  1  registered; one-shot ramp complete.
REQ-015 Port cfg_err  output  1  registered; active configuration invalid (lo >= hi).

Function
REQ-016 Config registers (mode_r, lo_r, hi_r, step_r) SHALL update only on cfg_load; mode/lo/hi/step are ignored otherwise.
REQ-017 On cfg_load: config regs <= inputs; out <= lo; dir <= 0; done <= 0; period <= 0; cfg_err <= (lo >= hi); cfg_load has priority over ena.
REQ-018 With ena low and no cfg_load, out/dir/done/cfg_err SHALL hold and period SHALL be 0.
REQ-019 With cfg_err=1 or step_r=0, out/dir/done SHALL hold and period SHALL stay 0 regardless of ena.
REQ-020 Arithmetic SHALL use N+1 bits; up = min(out+step_r, hi_r), down = max(out-step_r, lo_r); no wrap-around beyond bounds.
REQ-021 Triangle, dir=0: out <= up; if up == hi_r then dir <= 1.
REQ-022 Triangle, dir=1: out <= down; if down == lo_r then dir <= 0 and period pulses.
REQ-023 Saw-up: if out == hi_r then out <= lo_r and period pulses, else out <= up; dir stays 0.
REQ-024 Saw-down: if out == lo_r then out <= hi_r and period pulses, else out <= down; dir SHALL be 1 from the first enabled step.
REQ-025 One-shot: out <= up while done=0; when up == hi_r, done <= 1 and period pulses once; afterwards out holds at hi_r until cfg_load or rst.
REQ-026 period SHALL be asserted in the same cycle out first shows the boundary value; it SHALL never be high two consecutive cycles unless two boundaries occur in consecutive enabled steps.
REQ-027 Direction changes and period pulses SHALL occur only on enabled steps.
REQ-028 Latency: ena or cfg_load at edge k SHALL be reflected on outputs after edge k (one cycle).
REQ-029 Non-multiple steps SHALL clamp to the bound, not overshoot (e.g. lo=0, hi=10, step=4: 0,4,8,10,6,2,0).

Reset
REQ-030 On rst: lo_r=0, hi_r=2^N-1, step_r=1, mode_r=triangle; out=0, dir=0, period=0, done=0, cfg_err=0.
REQ-031 rst SHALL take priority over cfg_load and ena, including mid-ramp or mid-period.
REQ-032 After reset with ena held high and no cfg_load, the block SHALL produce a full-range step-1 triangle.

Verification
REQ-033 Reset, ena=1 for 510 cycles, N=8 -> out 0..255 then 254..0; dir=1 after out reaches 255; single period pulse when out returns to 0.
REQ-034 cfg_load mode=00 lo=0 hi=10 step=4, ena=1 -> out 0,4,8,10,6,2,0,4; period high only with the second 0.
REQ-035 cfg_load mode=01 lo=5 hi=9 step=3 -> out 5,8,9,5,8; period with each 5 after the first; then mode=10 same bounds -> 5,9,6,5,9.
REQ-036 cfg_load mode=11 lo=0 hi=7 step=2 -> 0,2,4,6,7; done=1 and period pulse with 7; out stays 7 for 20 further enabled cycles.
REQ-037 cfg_load lo=9 hi=9 -> cfg_err=1, out=9 frozen; step=0 valid config -> out frozen, no period.
REQ-038 Toggle ena every other cycle mid-triangle, then assert rst mid-ramp -> holds on ena=0 cycles; all outputs at reset values after the rst edge.

Source files
------------

// File: rtl/wave_generator.sv
// rtl/wave_generator.sv - Configurable triangle / saw / one-shot ramp generator.
// Bounds and step are captured on cfg_load; arithmetic is N+1 bits so steps clamp instead of wrapping.
module wave_generator #(
  parameter int N = 8,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         cfg_load,
  input  logic [1:0]   mode,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic [S-1:0] step,
  output logic [N-1:0] out,
  output logic         dir,
  output logic         period,
  output logic         done,
  output logic         cfg_err
);

  typedef enum logic [1:0] {
    MODE_TRI     = 2'b00,
    MODE_SAW_UP  = 2'b01,
    MODE_SAW_DN  = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  mode_e        mode_q, mode_d;
  logic [N-1:0] lo_q, lo_d;
  logic [N-1:0] hi_q, hi_d;
  logic [S-1:0] step_q, step_d;
  logic [N-1:0] out_q, out_d;
  logic         dir_q, dir_d;
  logic         period_q, period_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic [N:0]   out_x, step_x, lo_x, hi_x, up_sum;
  logic [N-1:0] step_n, up_val, dn_val;
  logic         active;

  assign out_x  = {1'b0, out_q};
  assign lo_x   = {1'b0, lo_q};
  assign hi_x   = {1'b0, hi_q};
  assign step_x = (N+1)'(step_q);
  assign step_n = N'(step_q);
  assign up_sum = out_x + step_x;

  // out - step < lo is tested as out < lo + step so the subtraction never underflows
  assign up_val = (up_sum >= hi_x) ? hi_q : up_sum[N-1:0];
  assign dn_val = (out_x < (lo_x + step_x)) ? lo_q : (out_q - step_n);

  assign active = ena && !err_q && (step_q != '0);

  always_comb begin
    mode_d   = mode_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    step_d   = step_q;
    out_d    = out_q;
    dir_d    = dir_q;
    done_d   = done_q;
    err_d    = err_q;
    period_d = 1'b0;
    if (cfg_load) begin
      mode_d = mode_e'(mode);
      lo_d   = lo;
      hi_d   = hi;
      step_d = step;
      out_d  = lo;
      dir_d  = 1'b0;
      done_d = 1'b0;
      err_d  = (lo >= hi);
    end else if (active) begin
      case (mode_q)
        MODE_TRI: begin
          if (!dir_q) begin
            out_d = up_val;
            if (up_val == hi_q) dir_d = 1'b1;
          end else begin
            out_d = dn_val;
            if (dn_val == lo_q) begin
              dir_d    = 1'b0;
              period_d = 1'b1;
            end
          end
        end
        MODE_SAW_UP: begin
          dir_d = 1'b0;
          if (out_q == hi_q) begin
            out_d    = lo_q;
            period_d = 1'b1;
          end else begin
            out_d = up_val;
          end
        end
        MODE_SAW_DN: begin
          dir_d = 1'b1;
          if (out_q == lo_q) begin
            out_d    = hi_q;
            period_d = 1'b1;
          end else begin
            out_d = dn_val;
          end
        end
        MODE_ONESHOT: begin
          if (!done_q) begin
            out_d = up_val;
            if (up_val == hi_q) begin
              done_d   = 1'b1;
              period_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_TRI;
      lo_q     <= '0;
      hi_q     <= '1;
      step_q   <= S'(1);
      out_q    <= '0;
      dir_q    <= 1'b0;
      period_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      step_q   <= step_d;
      out_q    <= out_d;
      dir_q    <= dir_d;
      period_q <= period_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign out     = out_q;
  assign dir     = dir_q;
  assign period  = period_q;
  assign done    = done_q;
  assign cfg_err = err_q;

endmodule
